// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control unit for a 32-bit MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and write-back
// over a single shared memory. Each memory access waits on mem_ready.
// The ALU function, operand selects and datapath enables are decoded combinationally
// from the current state and the instruction register fields.
//
// Memory handshake: in FETCH and MEM the controller raises mem_read or mem_write and
// keeps it high, with the address select stable, until the memory returns
// mem_ready=1. The access completes in the cycle where both the request and
// mem_ready are high. The FSM advances only on that cycle.
module mips_mc_ctrl #(
   parameter bit EXC_ENABLE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [5:0] alufun,
   output logic       sign,
   output logic [1:0] alu_src_a,
   output logic [2:0] alu_src_b,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       exc
);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_t;

   // ALU function codes
   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_A   = 6'b011010;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_NEQ = 6'b110001;
   localparam logic [5:0] ALU_LT  = 6'b110101;
   localparam logic [5:0] ALU_LEZ = 6'b111101;
   localparam logic [5:0] ALU_LTZ = 6'b111011;
   localparam logic [5:0] ALU_GTZ = 6'b111111;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   state_t state_q, state_d;

   // Instruction class flags and the ALU controls the instruction needs in EXEC.
   logic       is_rtype;
   logic       is_jr;
   logic       is_j;
   logic       is_jal;
   logic       is_branch;
   logic       is_lw;
   logic       is_sw;
   logic       is_legal;
   logic [5:0] ex_alufun;
   logic       ex_sign;
   logic [1:0] ex_src_a;
   logic [2:0] ex_src_b;

   // State register; reset wins over any pending memory access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Instruction decode: classify the IR fields and pick the EXEC-cycle ALU controls.
   always_comb begin
      is_rtype  = 1'b0;
      is_jr     = 1'b0;
      is_j      = 1'b0;
      is_jal    = 1'b0;
      is_branch = 1'b0;
      is_lw     = 1'b0;
      is_sw     = 1'b0;
      is_legal  = 1'b1;
      ex_alufun = ALU_ADD;
      ex_sign   = 1'b0;
      ex_src_a  = 2'd0;
      ex_src_b  = 3'd0;
      case (opcode)
         OP_RTYPE: begin
            // Register-register ops take rs and rt. Shifts see shamt on the rs input from the datapath.
            is_rtype = 1'b1;
            ex_src_a = 2'd1;
            ex_src_b = 3'd0;
            case (funct)
               FN_ADD:  begin ex_alufun = ALU_ADD; ex_sign = 1'b1; end
               FN_ADDU: begin ex_alufun = ALU_ADD; ex_sign = 1'b0; end
               FN_SUB:  begin ex_alufun = ALU_SUB; ex_sign = 1'b1; end
               FN_SUBU: begin ex_alufun = ALU_SUB; ex_sign = 1'b0; end
               FN_AND:  ex_alufun = ALU_AND;
               FN_OR:   ex_alufun = ALU_OR;
               FN_XOR:  ex_alufun = ALU_XOR;
               FN_NOR:  ex_alufun = ALU_NOR;
               FN_SLT:  begin ex_alufun = ALU_LT; ex_sign = 1'b1; end
               FN_SLTU: begin ex_alufun = ALU_LT; ex_sign = 1'b0; end
               FN_SLL:  ex_alufun = ALU_SLL;
               FN_SRL:  ex_alufun = ALU_SRL;
               FN_SRA:  ex_alufun = ALU_SRA;
               FN_JR: begin
                  is_rtype  = 1'b0;
                  is_jr     = 1'b1;
                  ex_alufun = ALU_A;
               end
               default: begin
                  is_rtype = 1'b0;
                  is_legal = 1'b0;
                  ex_src_a = 2'd0;
               end
            endcase
         end
         OP_REGIMM: begin
            // Only bltz (rt=0) is implemented in the REGIMM group.
            if (rt == 5'd0) begin
               is_branch = 1'b1;
               ex_alufun = ALU_LTZ;
               ex_sign   = 1'b1;
               ex_src_a  = 2'd1;
            end else begin
               is_legal = 1'b0;
            end
         end
         OP_J:   is_j   = 1'b1;
         OP_JAL: is_jal = 1'b1;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            is_branch = 1'b1;
            ex_sign   = 1'b1;
            ex_src_a  = 2'd1;
            case (opcode)
               OP_BEQ:  ex_alufun = ALU_EQ;
               OP_BNE:  ex_alufun = ALU_NEQ;
               OP_BLEZ: ex_alufun = ALU_LEZ;
               default: ex_alufun = ALU_GTZ;
            endcase
         end
         OP_ADDI:  begin ex_alufun = ALU_ADD; ex_sign = 1'b1; ex_src_a = 2'd1; ex_src_b = 3'd2; end
         OP_ADDIU: begin ex_alufun = ALU_ADD; ex_sign = 1'b0; ex_src_a = 2'd1; ex_src_b = 3'd2; end
         OP_SLTI:  begin ex_alufun = ALU_LT;  ex_sign = 1'b1; ex_src_a = 2'd1; ex_src_b = 3'd2; end
         OP_SLTIU: begin ex_alufun = ALU_LT;  ex_sign = 1'b0; ex_src_a = 2'd1; ex_src_b = 3'd2; end
         OP_ANDI:  begin ex_alufun = ALU_AND; ex_src_a = 2'd1; ex_src_b = 3'd4; end
         OP_ORI:   begin ex_alufun = ALU_OR;  ex_src_a = 2'd1; ex_src_b = 3'd4; end
         // lui shifts the zero-extended immediate left by the constant 16 on input A.
         OP_LUI:   begin ex_alufun = ALU_SLL; ex_src_a = 2'd2; ex_src_b = 3'd4; end
         OP_LW:    begin is_lw = 1'b1; ex_alufun = ALU_ADD; ex_src_a = 2'd1; ex_src_b = 3'd2; end
         OP_SW:    begin is_sw = 1'b1; ex_alufun = ALU_ADD; ex_src_a = 2'd1; ex_src_b = 3'd2; end
         default:  is_legal = 1'b0;
      endcase
      // An illegal instruction executes as an all-zero EXEC cycle when exceptions are off.
      if (!is_legal) begin
         ex_alufun = ALU_ADD;
         ex_sign   = 1'b0;
         ex_src_a  = 2'd0;
         ex_src_b  = 3'd0;
      end
   end

   // Next-state and output decode; every output defaults to 0 so unlisted signals stay low.
   always_comb begin
      state_d    = state_q;
      alufun     = ALU_ADD;
      sign       = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 3'd0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      exc        = 1'b0;
      unique case (state_q)
         ST_RST: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // Read the instruction at PC while the ALU forms PC+4; both commit together on mem_ready.
            mem_read  = 1'b1;
            alu_src_b = 3'd1;
            alufun    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // Precompute the branch target into ALUOut; jumps and exceptions finish here.
            alu_src_b = 3'd3;
            alufun    = ALU_ADD;
            if (is_j || is_jal) begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
               state_d  = ST_FETCH;
               if (is_jal) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
               end
            end else if (!is_legal && EXC_ENABLE) begin
               exc      = 1'b1;
               pc_write = 1'b1;
               pc_src   = 2'd3;
               state_d  = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alufun    = ex_alufun;
            sign      = ex_sign;
            alu_src_a = ex_src_a;
            alu_src_b = ex_src_b;
            if (is_jr) begin
               pc_write = 1'b1;
               pc_src   = 2'd0;
               state_d  = ST_FETCH;
            end else if (is_branch) begin
               // Taken branch loads the target precomputed in DECODE.
               pc_write = zero;
               pc_src   = 2'd1;
               state_d  = ST_FETCH;
            end else if (is_lw || is_sw) begin
               state_d = ST_MEM;
            end else if (is_legal) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_MEM: begin
            iord      = 1'b1;
            mem_read  = is_lw;
            mem_write = is_sw;
            if (mem_ready) begin
               state_d = is_lw ? ST_WB : ST_FETCH;
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_rtype ? 2'd1 : 2'd0;
            mem_to_reg = is_lw ? 2'd1 : 2'd0;
            state_d    = ST_FETCH;
         end
         default: begin
            state_d = ST_RST;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl. Two instances are used: one with exceptions enabled
// and one with exceptions disabled. Every cycle is compared against a per-phase
// model derived from the instruction's class.
module tb_mips_mc_ctrl;

   // clock / reset
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // phases and instruction classes of the reference model
   localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;
   localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                  K_JR = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

   localparam logic [5:0] A_ADD = 6'b000000, A_SUB = 6'b000001, A_AND = 6'b011000,
      A_OR = 6'b011110, A_XOR = 6'b010110, A_NOR = 6'b010001, A_A = 6'b011010,
      A_SLL = 6'b100000, A_SRL = 6'b100001, A_SRA = 6'b100011, A_EQ = 6'b110011,
      A_NEQ = 6'b110001, A_LT = 6'b110101, A_LEZ = 6'b111101, A_LTZ = 6'b111011,
      A_GTZ = 6'b111111;

   // DUT 0: EXC_ENABLE=1
   logic [5:0] opcode0, funct0;
   logic [4:0] rt0;
   logic       zero0, mem_ready0;
   logic [5:0] alufun0;
   logic       sign0, iord0, mem_read0, mem_write0, ir_write0, pc_write0, reg_write0, exc0;
   logic [1:0] alu_src_a0, pc_src0, reg_dst0, mem_to_reg0;
   logic [2:0] alu_src_b0;

   // DUT 1: EXC_ENABLE=0
   logic [5:0] opcode1, funct1;
   logic [4:0] rt1;
   logic       zero1, mem_ready1;
   logic [5:0] alufun1;
   logic       sign1, iord1, mem_read1, mem_write1, ir_write1, pc_write1, reg_write1, exc1;
   logic [1:0] alu_src_a1, pc_src1, reg_dst1, mem_to_reg1;
   logic [2:0] alu_src_b1;

   mips_mc_ctrl #(.EXC_ENABLE(1'b1)) dut0 (
      .clk(clk), .reset(reset), .opcode(opcode0), .funct(funct0), .rt(rt0),
      .zero(zero0), .mem_ready(mem_ready0), .alufun(alufun0), .sign(sign0),
      .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .iord(iord0),
      .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
      .pc_write(pc_write0), .pc_src(pc_src0), .reg_write(reg_write0),
      .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .exc(exc0)
   );

   mips_mc_ctrl #(.EXC_ENABLE(1'b0)) dut1 (
      .clk(clk), .reset(reset), .opcode(opcode1), .funct(funct1), .rt(rt1),
      .zero(zero1), .mem_ready(mem_ready1), .alufun(alufun1), .sign(sign1),
      .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .iord(iord1),
      .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
      .pc_write(pc_write1), .pc_src(pc_src1), .reg_write(reg_write1),
      .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .exc(exc1)
   );

   // packed view: alufun,sign,src_a,src_b,iord,mem_read,mem_write,ir_write,pc_write,pc_src,reg_write,reg_dst,mem_to_reg,exc
   logic [24:0] out0, out1;
   assign out0 = {alufun0, sign0, alu_src_a0, alu_src_b0, iord0, mem_read0, mem_write0,
                  ir_write0, pc_write0, pc_src0, reg_write0, reg_dst0, mem_to_reg0, exc0};
   assign out1 = {alufun1, sign1, alu_src_a1, alu_src_b1, iord1, mem_read1, mem_write1,
                  ir_write1, pc_write1, pc_src1, reg_write1, reg_dst1, mem_to_reg1, exc1};

   int checks = 0;
   int errors = 0;

   // reference model: instruction class and EXEC-cycle ALU controls
   function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rtv,
                                 output int kind, output logic [5:0] af, output logic sg,
                                 output logic [1:0] sa, output logic [2:0] sb);
      kind = K_ILL; af = A_ADD; sg = 1'b0; sa = 2'd0; sb = 3'd0;
      if (op == 6'h00) begin
         kind = K_RALU; sa = 2'd1;
         case (fn)
            6'h20: begin af = A_ADD; sg = 1'b1; end
            6'h21: af = A_ADD;
            6'h22: begin af = A_SUB; sg = 1'b1; end
            6'h23: af = A_SUB;
            6'h24: af = A_AND;
            6'h25: af = A_OR;
            6'h26: af = A_XOR;
            6'h27: af = A_NOR;
            6'h2A: begin af = A_LT; sg = 1'b1; end
            6'h2B: af = A_LT;
            6'h00: af = A_SLL;
            6'h02: af = A_SRL;
            6'h03: af = A_SRA;
            6'h08: begin kind = K_JR; af = A_A; end
            default: begin kind = K_ILL; sa = 2'd0; end
         endcase
      end else begin
         case (op)
            6'h01: if (rtv == 5'd0) begin kind = K_BR; af = A_LTZ; sg = 1'b1; sa = 2'd1; end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            6'h04: begin kind = K_BR; af = A_EQ;  sg = 1'b1; sa = 2'd1; end
            6'h05: begin kind = K_BR; af = A_NEQ; sg = 1'b1; sa = 2'd1; end
            6'h06: begin kind = K_BR; af = A_LEZ; sg = 1'b1; sa = 2'd1; end
            6'h07: begin kind = K_BR; af = A_GTZ; sg = 1'b1; sa = 2'd1; end
            6'h08: begin kind = K_IALU; af = A_ADD; sg = 1'b1; sa = 2'd1; sb = 3'd2; end
            6'h09: begin kind = K_IALU; af = A_ADD; sa = 2'd1; sb = 3'd2; end
            6'h0A: begin kind = K_IALU; af = A_LT;  sg = 1'b1; sa = 2'd1; sb = 3'd2; end
            6'h0B: begin kind = K_IALU; af = A_LT;  sa = 2'd1; sb = 3'd2; end
            6'h0C: begin kind = K_IALU; af = A_AND; sa = 2'd1; sb = 3'd4; end
            6'h0D: begin kind = K_IALU; af = A_OR;  sa = 2'd1; sb = 3'd4; end
            6'h0F: begin kind = K_IALU; af = A_SLL; sa = 2'd2; sb = 3'd4; end
            6'h23: begin kind = K_LW; sa = 2'd1; sb = 3'd2; end
            6'h2B: begin kind = K_SW; sa = 2'd1; sb = 3'd2; end
            default: kind = K_ILL;
         endcase
      end
   endfunction

   // expected output vector for one cycle of a given phase
   function automatic logic [24:0] expect_out(input int p, input int kind, input logic [5:0] af,
                                              input logic sg, input logic [1:0] sa, input logic [2:0] sb,
                                              input bit exc_en, input logic rdy, input logic z);
      logic [5:0] e_af; logic e_sg; logic [1:0] e_sa; logic [2:0] e_sb;
      logic e_iord, e_mr, e_mw, e_irw, e_pcw, e_rw, e_exc;
      logic [1:0] e_pcs, e_rd, e_m2r;
      e_af = 6'd0; e_sg = 1'b0; e_sa = 2'd0; e_sb = 3'd0;
      e_iord = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_irw = 1'b0; e_pcw = 1'b0; e_rw = 1'b0; e_exc = 1'b0;
      e_pcs = 2'd0; e_rd = 2'd0; e_m2r = 2'd0;
      case (p)
         P_F: begin
            e_mr = 1'b1; e_sb = 3'd1; e_af = A_ADD;
            if (rdy) begin e_irw = 1'b1; e_pcw = 1'b1; end
         end
         P_D: begin
            e_sb = 3'd3; e_af = A_ADD;
            if (kind == K_J || kind == K_JAL) begin e_pcw = 1'b1; e_pcs = 2'd2; end
            if (kind == K_JAL) begin e_rw = 1'b1; e_rd = 2'd2; e_m2r = 2'd2; end
            if (kind == K_ILL && exc_en) begin e_exc = 1'b1; e_pcw = 1'b1; e_pcs = 2'd3; end
         end
         P_E: begin
            e_af = af; e_sg = sg; e_sa = sa; e_sb = sb;
            if (kind == K_JR) e_pcw = 1'b1;
            if (kind == K_BR) begin e_pcw = z; e_pcs = 2'd1; end
         end
         P_M: begin
            e_iord = 1'b1; e_mr = (kind == K_LW); e_mw = (kind == K_SW);
         end
         default: begin
            e_rw = 1'b1;
            e_rd = (kind == K_RALU) ? 2'd1 : 2'd0;
            e_m2r = (kind == K_LW) ? 2'd1 : 2'd0;
         end
      endcase
      return {e_af, e_sg, e_sa, e_sb, e_iord, e_mr, e_mw, e_irw, e_pcw, e_pcs, e_rw, e_rd, e_m2r, e_exc};
   endfunction

   // driver + check for one cycle: drive at negedge, compare 1 time unit later
   task automatic step(input int which, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rtv,
                       input logic z, input int p, input logic rdy, input string name);
      int kind; logic [5:0] af; logic sg; logic [1:0] sa; logic [2:0] sb;
      logic [24:0] exp_v, obs;
      model(op, fn, rtv, kind, af, sg, sa, sb);
      @(negedge clk);
      if (which == 0) begin
         opcode0 = op; funct0 = fn; rt0 = rtv; zero0 = z; mem_ready0 = rdy; mem_ready1 = 1'b0;
      end else begin
         opcode1 = op; funct1 = fn; rt1 = rtv; zero1 = z; mem_ready1 = rdy; mem_ready0 = 1'b0;
      end
      #1;
      exp_v = expect_out(p, kind, af, sg, sa, sb, (which == 0), rdy, z);
      obs = (which == 0) ? out0 : out1;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s dut%0d op=%h fn=%h phase=%0d: got %h expected %h", name, which, op, fn, p, obs, exp_v);
      end
   endtask

   // run one whole instruction with fwait/mwait not-ready cycles in FETCH/MEM
   task automatic run_instr(input int which, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rtv,
                            input logic z, input int fwait, input int mwait, input string name);
      int kind; logic [5:0] af; logic sg; logic [1:0] sa; logic [2:0] sb;
      int ph[$]; int waits; logic rdy;
      model(op, fn, rtv, kind, af, sg, sa, sb);
      ph.push_back(P_F); ph.push_back(P_D);
      if (!(kind == K_J || kind == K_JAL || (kind == K_ILL && which == 0))) ph.push_back(P_E);
      if (kind == K_LW || kind == K_SW) ph.push_back(P_M);
      if (kind == K_RALU || kind == K_IALU || kind == K_LW) ph.push_back(P_W);
      foreach (ph[i]) begin
         waits = (ph[i] == P_F) ? fwait : (ph[i] == P_M) ? mwait : 0;
         for (int c = 0; c <= waits; c++) begin
            if (ph[i] == P_F || ph[i] == P_M) rdy = (c == waits);
            else rdy = 1'($urandom_range(0, 1));
            step(which, op, fn, rtv, z, ph[i], rdy, name);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (out0 !== 25'd0) begin errors++; $display("FAIL reset_rst dut0: got %h expected 0", out0); end
      checks++;
      if (out1 !== 25'd0) begin errors++; $display("FAIL reset_rst dut1: got %h expected 0", out1); end
      reset = 1'b0;
      // sw to MEM and hold it there, then reset in the middle of the write
      step(0, 6'h2B, 6'h15, 5'd3, 1'b0, P_F, 1'b1, "rst_sw");
      step(0, 6'h2B, 6'h15, 5'd3, 1'b0, P_D, 1'b0, "rst_sw");
      step(0, 6'h2B, 6'h15, 5'd3, 1'b0, P_E, 1'b1, "rst_sw");
      step(0, 6'h2B, 6'h15, 5'd3, 1'b0, P_M, 1'b0, "rst_sw_mem");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (out0 !== 25'd0) begin errors++; $display("FAIL reset_from_mem dut0: got %h expected 0", out0); end
      checks++;
      if (out1 !== 25'd0) begin errors++; $display("FAIL reset_from_mem dut1: got %h expected 0", out1); end
      step(0, 6'h2B, 6'h15, 5'd3, 1'b0, P_F, 1'b0, "after_reset_fetch");
      step(0, 6'h2B, 6'h15, 5'd3, 1'b0, P_F, 1'b0, "after_reset_fetch_hold");
   endtask

   task automatic test_add();
      run_instr(0, 6'h00, 6'h20, 5'($urandom), 1'($urandom), 0, 0, "add");
      run_instr(0, 6'h00, 6'h23, 5'($urandom), 1'($urandom), 1, 0, "subu");
   endtask

   task automatic test_lw_wait();
      // 2 waits in FETCH + 3 in MEM: 10 cycles total
      run_instr(0, 6'h23, 6'($urandom), 5'($urandom), 1'($urandom), 2, 3, "lw_wait");
      run_instr(0, 6'h2B, 6'($urandom), 5'($urandom), 1'($urandom), 0, 2, "sw_wait");
   endtask

   task automatic test_branch();
      run_instr(0, 6'h04, 6'($urandom), 5'($urandom), 1'b1, 0, 0, "beq_taken");
      run_instr(0, 6'h04, 6'($urandom), 5'($urandom), 1'b0, 0, 0, "beq_not_taken");
      run_instr(0, 6'h01, 6'($urandom), 5'd0, 1'b1, 1, 0, "bltz");
      run_instr(0, 6'h00, 6'h08, 5'($urandom), 1'($urandom), 0, 0, "jr");
      run_instr(0, 6'h03, 6'($urandom), 5'($urandom), 1'($urandom), 0, 0, "jal");
   endtask

   task automatic test_lui();
      run_instr(0, 6'h0F, 6'($urandom), 5'($urandom), 1'($urandom), 0, 0, "lui");
   endtask

   task automatic test_illegal();
      run_instr(0, 6'h3F, 6'($urandom), 5'($urandom), 1'($urandom), 0, 0, "illegal_exc");
      run_instr(1, 6'h3F, 6'($urandom), 5'($urandom), 1'($urandom), 0, 0, "illegal_nop");
      run_instr(0, 6'h00, 6'h01, 5'($urandom), 1'($urandom), 0, 0, "illegal_funct_exc");
      run_instr(1, 6'h01, 6'($urandom), 5'd1, 1'($urandom), 1, 0, "illegal_regimm_nop");
      run_instr(1, 6'h23, 6'($urandom), 5'($urandom), 1'($urandom), 0, 1, "lw_noexc_dut");
   endtask

   logic [5:0] r_fn_tab [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
   logic [5:0] i_op_tab [16] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
   logic [5:0] bad_op_tab [4] = '{6'h3F, 6'h0E, 6'h10, 6'h30};

   task automatic test_back_to_back();
      logic [5:0] op, fn; logic [4:0] rtv; int r, which;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         fn = 6'($urandom);
         rtv = 5'($urandom);
         if (r < 4) begin
            op = 6'h00; fn = r_fn_tab[$urandom_range(0, 13)];
         end else if (r < 9) begin
            op = i_op_tab[$urandom_range(0, 15)];
            if (op == 6'h01 && $urandom_range(0, 1) == 0) rtv = 5'd0;
         end else begin
            op = bad_op_tab[$urandom_range(0, 3)];
         end
         which = $urandom_range(0, 1);
         run_instr(which, op, fn, rtv, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end
      // both controllers must be back in FETCH
      step(0, 6'h00, 6'h20, 5'd0, 1'b0, P_F, 1'b0, "final_fetch");
      step(1, 6'h00, 6'h20, 5'd0, 1'b0, P_F, 1'b0, "final_fetch");
   endtask

   initial begin
      reset = 1'b1;
      opcode0 = 6'd0; funct0 = 6'd0; rt0 = 5'd0; zero0 = 1'b0; mem_ready0 = 1'b0;
      opcode1 = 6'd0; funct1 = 6'd0; rt1 = 5'd0; zero1 = 1'b0; mem_ready1 = 1'b0;
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_lui();
      test_illegal();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the 32-bit MIPS datapath.
- It is the driving end of the ALU interface: it issues alufun/sign each state and consumes the ALU zero flag to resolve branches.
- It sequences fetch, decode, execute, memory and write-back for a single shared memory with a ready handshake.
- It sits between the instruction register fields and the datapath muxes and enables.

Parameters:
- EXC_ENABLE, 1, when 1 an unsupported opcode/funct raises exc and vectors; when 0 it executes as NOP.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16], distinguishes REGIMM
- zero  in  1  ALU zero/condition flag
- mem_ready  in  1  memory completes the current access this cycle
- alufun  out  6  ALU function code
- sign  out  1  signed arithmetic/compare
- alu_src_a  out  2  0=PC, 1=rs, 2=const 16
- alu_src_b  out  3  0=rt, 1=const 4, 2=sext imm, 3=sext imm<<2, 4=zext imm
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction
- pc_write  out  1  load PC
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=exception vector
- reg_write  out  1  register file write
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- exc  out  1  one-cycle illegal-instruction pulse

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB. 3-bit register.
- Outputs are decoded combinationally from state, IR fields, zero and mem_ready.
- Reset:
  - reset=1 at a clock edge sets state=RST from any state, including a pending MEM access.
  - In RST all outputs are 0; the next cycle goes to FETCH.
- ALU codes:
  - ADD 000000, SUB 000001
  - AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010
  - SLL 100000, SRL 100001, SRA 100011
  - EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111
- FETCH:
  - Drive mem_read=1, iord=0, src_a=0, src_b=1, alufun=ADD.
  - Hold while mem_ready=0.
  - On mem_ready=1 assert ir_write=1, pc_write=1, pc_src=0 in the same cycle, then go to DECODE.
- DECODE:
  - src_a=0, src_b=3, alufun=ADD (branch target into ALUOut).
  - j: pc_write=1, pc_src=2, then FETCH.
  - jal: additionally reg_write=1, reg_dst=2, mem_to_reg=2.
  - Illegal with EXC_ENABLE=1: exc=1, pc_write=1, pc_src=3, then FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: src_a=1, src_b=0, alufun from funct (add/sub sign=1; addu/subu/sltu sign=0; slt sign=1), then WB.
  - sll/srl/sra: src_a=1 carries shamt from datapath; the same alufun rule applies.
  - jr: src_a=1, alufun=A, pc_write=1, pc_src=0, then FETCH.
  - addi/slti: src_b=2, sign=1. addiu/sltiu: src_b=2, sign=0. andi/ori: src_b=4. All go to WB.
  - lui: src_a=2, src_b=4, alufun=SLL, then WB.
  - Branches use alufun EQ/NEQ/LEZ/GTZ, and LTZ for REGIMM rt=0. sign=1, src_a=1, src_b=0.
  - Branch resolution: pc_write=zero, pc_src=1, then FETCH.
  - lw/sw: src_a=1, src_b=2, ADD, then MEM.
- MEM:
  - iord=1; lw asserts mem_read, sw asserts mem_write, held until mem_ready.
  - On mem_ready: sw goes to FETCH, lw goes to WB.
- WB:
  - reg_write=1 for exactly one cycle, then FETCH.
  - lw: mem_to_reg=1, reg_dst=0.
  - R-type: reg_dst=1.
  - I-type: reg_dst=0.
- Any output not listed for a state is 0.
- Latencies (mem_ready=1 immediately):
  - R-type/I-type ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch/jr: 3 cycles
  - j/jal: 2 cycles
- Each wait cycle adds exactly 1 cycle.

Test Plan:
- Reset while in MEM with mem_write=1 → next cycle all outputs 0 (RST), then FETCH with mem_read=1.
- add (op 0, funct 0x20), mem_ready=1 → states FETCH, DECODE, EXEC (alufun 000000, sign 1), WB (reg_write 1, reg_dst 1) → FETCH.
- lw (op 0x23) with mem_ready low for 2 cycles in FETCH and 3 in MEM → 10 cycles total; mem_read held throughout the waits; reg_write=1 with mem_to_reg=1 in the last cycle.
- beq (op 0x04): EXEC shows alufun 110011; zero=1 → pc_write=1, pc_src=1; zero=0 → pc_write=0; both return to FETCH.
- lui (op 0x0F) → EXEC alufun 100000, src_a=2, src_b=4; WB reg_dst=0.
- Illegal op 0x3F with EXC_ENABLE=1 → DECODE exc=1, pc_write=1, pc_src=3, then FETCH; with EXC_ENABLE=0 → exc=0 and no register or memory write.
